// File: rtl/tmr_irq_arbiter.sv
// Purpose : arbitrates the six 8-bit-timer interrupt requests (fixed or rotating
//           priority), offers the winner to the CPU, and strobes the owning TCSR flag clear.
// Latency : irq_src rise -> irq_valid after 2 cycles; ack -> flag_clr on the next cycle.
// Backpressure: the offer is held until irq_ack, a withdraw, or ACK_TIMEOUT cycles.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   irq_src       level requests {OVI1,CMIB1,CMIA1,OVI0,CMIB0,CMIA0}
//   irq_mask      1 = source masked (used live, not registered)
//   irq_ack       CPU accepts the offered vector (ignored outside OFFER)
//   err_clr       clears the sticky timeout_err
//   irq_valid     vector offered to the CPU
//   irq_vector    index of the granted source
//   flag_clr      one-hot, one-cycle clear strobe to the granted TCSR flag
//   pending       registered requests that are not masked
//   timeout_err   sticky abort indicator
//   busy          a transaction is in progress
module tmr_irq_arbiter #(
  parameter int NUM_SRC     = 6,
  parameter int VEC_WIDTH   = 3,
  parameter int ROUND_ROBIN = 0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic [NUM_SRC-1:0]   irq_mask,
  input  logic                 irq_ack,
  input  logic                 err_clr,
  output logic                 irq_valid,
  output logic [VEC_WIDTH-1:0] irq_vector,
  output logic [NUM_SRC-1:0]   flag_clr,
  output logic [NUM_SRC-1:0]   pending,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // The counter is compared before it increments, so an abort happens on the
  // edge where it would reach ACK_TIMEOUT: the offer lasts ACK_TIMEOUT cycles.
  localparam logic [7:0]         TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [VEC_WIDTH:0] NSRC_W   = (VEC_WIDTH+1)'(NUM_SRC);
  localparam logic [VEC_WIDTH-1:0] LAST_SRC = VEC_WIDTH'(NUM_SRC - 1);

  logic [1:0]           state_q, state_d;
  logic [NUM_SRC-1:0]   src_q;
  logic [VEC_WIDTH-1:0] grant_q, grant_d;
  logic [VEC_WIDTH-1:0] rr_q, rr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_SRC-1:0]   fclr_q, fclr_d;
  logic                 err_q, err_d;
  logic                 err_set;

  logic [NUM_SRC-1:0]   cand;
  logic [VEC_WIDTH-1:0] start;
  logic [VEC_WIDTH-1:0] win;
  logic [VEC_WIDTH:0]   idx;
  logic                 found;
  logic [VEC_WIDTH-1:0] ptr_inc;

  assign cand  = src_q & ~irq_mask;
  // Fixed priority is simply a rotating search that always starts at index 0.
  assign start = (ROUND_ROBIN != 0) ? rr_q : '0;

  // First candidate at or after 'start', wrapping from NUM_SRC-1 back to 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, start} + (VEC_WIDTH+1)'(k);
      if (idx >= NSRC_W) begin
        idx = idx - NSRC_W;
      end
      if (!found && cand[idx[VEC_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = idx[VEC_WIDTH-1:0];
      end
    end
  end

  assign ptr_inc = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    fclr_d  = '0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          grant_d = win;
          cnt_d   = '0;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // Ack beats withdraw, withdraw beats timeout.
        if (irq_ack) begin
          fclr_d[grant_q] = 1'b1;
          cnt_d   = '0;
          rr_d    = ptr_inc;
          state_d = ST_WAIT;
        end else if (!cand[grant_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_set = 1'b1;
          rr_d    = ptr_inc;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        // Unmasked view: the flag itself must fall, masking does not end the wait.
        if (!src_q[grant_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_set = 1'b1;
          rr_d    = ptr_inc;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new abort wins over a simultaneous clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      fclr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= irq_src;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      fclr_q  <= fclr_d;
      err_q   <= err_d;
    end
  end

  assign irq_valid   = (state_q == ST_OFFER);
  assign irq_vector  = grant_q;
  assign flag_clr    = fclr_q;
  assign pending     = cand;
  assign timeout_err = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
